bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single memory-mapped peripheral bus (SPART, timers, etc.)
//  between NUM_MASTERS requesters (CPU data port, bootloader, DMA). Grants one master at a time,
//  muxes its read/write/addr/wdata onto the slave bus, routes ack/rdata back, and frees the bus on ack.
//  Replaces tri-state bus sharing with an explicit point-to-point mux.
// PARAMETERS
//  NUM_MASTERS     3    number of requesters; index 0 wins the first arbitration after reset
//  ADDR_W          32   bus address width
//  DATA_W          32   bus data width
//  TIMEOUT_CYCLES  255  cycles in BUSY without s_ack_i before abort (only with BUS_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                   clock, all logic on posedge
//  rst          in   1                   asynchronous, active-high reset
//  m_read_i     in   NUM_MASTERS         per-master read request, held until m_ack_o
//  m_write_i    in   NUM_MASTERS         per-master write request, held until m_ack_o
//  m_addr_i     in   NUM_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
//  m_wdata_i    in   NUM_MASTERS*DATA_W  per-master write data, same packing
//  m_gnt_o      out  NUM_MASTERS         one-hot grant, registered
//  m_ack_o      out  NUM_MASTERS         one-cycle ack to the granted master
//  m_err_o      out  NUM_MASTERS         one-cycle error to the granted master
//  m_rdata_o    out  DATA_W              s_rdata_i passed through, valid with m_ack_o
//  s_read_o     out  1                   slave bus read strobe
//  s_write_o    out  1                   slave bus write strobe
//  s_addr_o     out  ADDR_W              slave bus address
//  s_wdata_o    out  DATA_W              slave bus write data
//  s_rdata_i    in   DATA_W              slave read data
//  s_ack_i      in   1                   slave completion, one cycle
// BEHAVIOUR
//  - Reset: state=IDLE, m_gnt_o=0, pointer=NUM_MASTERS-1, all strobes/acks/errs 0, s_addr_o/s_wdata_o 0.
//    Reset mid-transfer drops the grant immediately. No ack is issued.
//  - Request of master i = m_read_i[i] | m_write_i[i].
//  - FSM states: IDLE, BUSY.
//  - IDLE:
//      - s_read_o and s_write_o are 0.
//      - If any request is present, pick the first requester searching upward from pointer+1 (mod NUM_MASTERS).
//      - Register that one-hot grant. Set pointer to the winner. Go to BUSY.
//      - Grant latency is 1 cycle after the request appears.
//  - BUSY: s_* outputs are a combinational mux of the granted master's inputs.
//      - s_ack_i=1: in the same cycle m_ack_o[g]=1 and m_rdata_o=s_rdata_i. Next cycle clear grant, go to IDLE.
//        The bus therefore has a one-cycle idle gap between grants.
//      - m_read_i[g] & m_write_i[g] both 1: protocol error. Suppress the slave strobes, pulse m_err_o[g],
//        go to IDLE.
//      - Granted master drops its request before ack: go to IDLE. No ack, no err. Pointer keeps the winner.
//      - s_ack_i while in IDLE: ignore it.
//  - Requests from non-granted masters stall; they are never dropped or acked.
//  - Fairness: with all masters requesting continuously, grants rotate 0,1,2,0,...
//  - m_gnt_o is always one-hot or zero.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//      - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on grant and increments every BUSY cycle.
//      - When it equals TIMEOUT_CYCLES and s_ack_i=0: pulse m_err_o[g], drop s_* strobes, go to IDLE.
//      - s_ack_i arriving in the same cycle as the timeout wins: ack, no err.
//  BUS_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for s_ack_i.
//      - m_err_o asserts only on the read+write protocol error.
// STRUCTURE
//  - bus_pkg: arb_state_t enum {IDLE, BUSY}, BUS_ADDR_W/BUS_DATA_W constants, SPART_BASE=32'h1C.
//  - Sub-module bus_rr_pick: combinational rotate-priority pick (req vector, pointer -> one-hot winner, index).
// TESTING
//  1. Single request: m_write_i[1]=1, addr=0x1C, wdata=0x42.
//     -> gnt=3'b010 next cycle; s_write_o=1, s_addr_o=0x1C, s_wdata_o=0x42; ack on cycle s_ack_i=1.
//  2. All 3 masters request reads continuously; slave acks 1 cycle after strobe.
//     -> grant order 0,1,2,0,1,2; no master starved.
//  3. Read: m_read_i[2], addr=0x1D, slave returns 0x000000A5 with ack.
//     -> m_ack_o=3'b100, m_rdata_o=0xA5 in the same cycle.
//  4. Master 0 asserts read and write together while granted.
//     -> s_read_o=s_write_o=0, m_err_o[0] pulses 1 cycle, FSM returns to IDLE.
//  5. rst asserted mid-BUSY -> m_gnt_o=0 and s_* strobes 0 asynchronously.
//     -> After release, master 0 wins the first arbitration.
//  6. BUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no s_ack_i.
//     -> m_err_o[g] pulses after 8 BUSY cycles; the next requester is granted.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the peripheral-bus arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   BUS_ADDR_W  : default bus address width
//   BUS_DATA_W  : default bus data width
//   SPART_BASE  : base address of the SPART peripheral on this bus
// -----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   localparam logic [31:0] SPART_BASE = 32'h0000_001C;

endpackage : bus_pkg

// File: rtl/bus_rr_pick.sv
// -----------------------------------------------------------------------------
// bus_rr_pick
// Combinational rotate-priority picker. Searches the request vector upward
// starting at ptr_i+1 (wrapping modulo N) and returns the first requester.
// Ports:
//   req_i  in  N    request vector
//   ptr_i  in  PW   index of the previous winner
//   gnt_o  out N    one-hot winner (zero when no request)
//   idx_o  out PW   index of the winner (zero when no request)
//   any_o  out 1    at least one request present
// -----------------------------------------------------------------------------
module bus_rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   // Rotating first-one search, the previous winner being checked last.
   always_comb begin
      logic          found;
      logic [PW-1:0] cand;
      found = 1'b0;
      cand  = '0;
      gnt_o = '0;
      idx_o = '0;
      for (int k = 1; k <= N; k++) begin
         cand = PW'((int'(ptr_i) + k) % N);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end else begin
            found = found;
         end
      end
      any_o = |req_i;
   end

endmodule : bus_rr_pick

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter sharing one memory-mapped peripheral bus between
// NUM_MASTERS requesters. One master is granted at a time; its strobes,
// address and write data are muxed onto the slave bus, and ack/rdata are
// routed back. The bus is released on ack, on a read+write protocol error,
// or when the granted master withdraws its request.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   When defined, a BUSY cycle counter aborts a transfer with m_err_o after
//   TIMEOUT_CYCLES cycles without s_ack_i. When undefined, BUSY waits forever.
//
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   m_read_i     per-master read request (held until ack)
//   m_write_i    per-master write request (held until ack)
//   m_addr_i     packed per-master address, master i at [i*ADDR_W +: ADDR_W]
//   m_wdata_i    packed per-master write data, same packing
//   m_gnt_o      registered one-hot grant
//   m_ack_o      one-cycle ack to the granted master
//   m_err_o      one-cycle error to the granted master
//   m_rdata_o    slave read data, valid with m_ack_o
//   s_read_o     slave read strobe
//   s_write_o    slave write strobe
//   s_addr_o     slave address
//   s_wdata_o    slave write data
//   s_rdata_i    slave read data
//   s_ack_i      slave completion pulse
// -----------------------------------------------------------------------------
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int ADDR_W         = BUS_ADDR_W,
   parameter int DATA_W         = BUS_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS-1:0]        m_read_i,
   input  logic [NUM_MASTERS-1:0]        m_write_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
   output logic [NUM_MASTERS-1:0]        m_gnt_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic [DATA_W-1:0]             m_rdata_o,
   output logic                          s_read_o,
   output logic                          s_write_o,
   output logic [ADDR_W-1:0]             s_addr_o,
   output logic [DATA_W-1:0]             s_wdata_o,
   input  logic [DATA_W-1:0]             s_rdata_i,
   input  logic                          s_ack_i
);

   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;

   logic [NUM_MASTERS-1:0] req_s;
   logic [NUM_MASTERS-1:0] pick_gnt_s;
   logic [PTR_W-1:0]       pick_idx_s;
   logic                   pick_any_s;

   logic                   sel_read_s;
   logic                   sel_write_s;
   logic [ADDR_W-1:0]      sel_addr_s;
   logic [DATA_W-1:0]      sel_wdata_s;

   logic                   busy_s;
   logic                   dropped_s;
   logic                   proto_err_s;
   logic                   timeout_s;
   logic                   ack_ok_s;
   logic                   err_s;

   assign req_s = m_read_i | m_write_i;

   bus_rr_pick #(
      .N  (NUM_MASTERS),
      .PW (PTR_W)
   ) u_pick (
      .req_i (req_s),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt_s),
      .idx_o (pick_idx_s),
      .any_o (pick_any_s)
   );

   // AND-OR mux of the granted master's request; all zero when nobody is granted.
   always_comb begin
      sel_read_s  = |(m_read_i & gnt_q);
      sel_write_s = |(m_write_i & gnt_q);
      sel_addr_s  = '0;
      sel_wdata_s = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (gnt_q[i]) begin
            sel_addr_s  = sel_addr_s  | m_addr_i[i*ADDR_W +: ADDR_W];
            sel_wdata_s = sel_wdata_s | m_wdata_i[i*DATA_W +: DATA_W];
         end else begin
            sel_addr_s  = sel_addr_s;
            sel_wdata_s = sel_wdata_s;
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // BUSY cycle counter, cleared whenever a new grant is issued.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A same-cycle slave ack overrides the timeout.
   assign timeout_s = busy_s && (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !s_ack_i;
`else
   assign timeout_s = 1'b0;
`endif

   // Transfer outcome qualifiers; a withdrawn request ends the transfer silently.
   always_comb begin
      busy_s      = (state_q == BUSY);
      dropped_s   = busy_s && !(sel_read_s || sel_write_s);
      proto_err_s = busy_s && sel_read_s && sel_write_s;
      ack_ok_s    = busy_s && !dropped_s && !proto_err_s && s_ack_i;
      err_s       = busy_s && !dropped_s && (proto_err_s || timeout_s);
   end

   // Slave-side and master-side outputs.
   always_comb begin
      s_read_o  = sel_read_s  && !proto_err_s && !timeout_s;
      s_write_o = sel_write_s && !proto_err_s && !timeout_s;
      s_addr_o  = sel_addr_s;
      s_wdata_o = sel_wdata_s;
      m_gnt_o   = gnt_q;
      m_ack_o   = gnt_q & {NUM_MASTERS{ack_ok_s}};
      m_err_o   = gnt_q & {NUM_MASTERS{err_s}};
      if (ack_ok_s) begin
         m_rdata_o = s_rdata_i;
      end else begin
         m_rdata_o = '0;
      end
   end

   // Arbiter next-state logic.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_any_s) begin
               state_d = BUSY;
               gnt_d   = pick_gnt_s;
               ptr_d   = pick_idx_s;
            end else begin
               gnt_d   = '0;
            end
         end
         BUSY: begin
            if (dropped_s || proto_err_s || ack_ok_s || timeout_s) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= PTR_W'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed self-checking bench for bus_arbiter with three masters.
// Define BUS_ARB_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic [N-1:0]    m_read_i;
   logic [N-1:0]    m_write_i;
   logic [N*AW-1:0] m_addr_i;
   logic [N*DW-1:0] m_wdata_i;
   logic [N-1:0]    m_gnt_o;
   logic [N-1:0]    m_ack_o;
   logic [N-1:0]    m_err_o;
   logic [DW-1:0]   m_rdata_o;
   logic            s_read_o;
   logic            s_write_o;
   logic [AW-1:0]   s_addr_o;
   logic [DW-1:0]   s_wdata_o;
   logic [DW-1:0]   s_rdata_i;
   logic            s_ack_i;

   int n_checks;
   int n_fail;

   bus_arbiter #(
      .NUM_MASTERS    (N),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_read_i  (m_read_i),
      .m_write_i (m_write_i),
      .m_addr_i  (m_addr_i),
      .m_wdata_i (m_wdata_i),
      .m_gnt_o   (m_gnt_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_rdata_o (m_rdata_o),
      .s_read_o  (s_read_o),
      .s_write_o (s_write_o),
      .s_addr_o  (s_addr_o),
      .s_wdata_o (s_wdata_o),
      .s_rdata_i (s_rdata_i),
      .s_ack_i   (s_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      logic [N-1:0] exp_g;
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      m_read_i  = '0;
      m_write_i = '0;
      m_addr_i  = '0;
      m_wdata_i = '0;
      s_rdata_i = '0;
      s_ack_i   = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_gnt",   64'(m_gnt_o),   64'h0);
      chk("rst_ack",   64'(m_ack_o),   64'h0);
      chk("rst_err",   64'(m_err_o),   64'h0);
      chk("rst_srd",   64'(s_read_o),  64'h0);
      chk("rst_swr",   64'(s_write_o), 64'h0);
      chk("rst_saddr", 64'(s_addr_o),  64'h0);
      chk("rst_swd",   64'(s_wdata_o), 64'h0);
      rst = 1'b0;
      tick();

      // 1. Single write from master 1
      m_write_i[1] = 1'b1;
      m_addr_i[1*AW +: AW]  = SPART_BASE;
      m_wdata_i[1*DW +: DW] = 32'h0000_0042;
      settle();
      chk("t1_gnt_lat", 64'(m_gnt_o), 64'h0);
      tick();
      chk("t1_gnt",   64'(m_gnt_o),   64'h2);
      chk("t1_swr",   64'(s_write_o), 64'h1);
      chk("t1_srd",   64'(s_read_o),  64'h0);
      chk("t1_saddr", 64'(s_addr_o),  64'h1C);
      chk("t1_swd",   64'(s_wdata_o), 64'h42);
      chk("t1_noack", 64'(m_ack_o),   64'h0);
      s_ack_i = 1'b1;
      settle();
      chk("t1_ack",   64'(m_ack_o),   64'h2);
      chk("t1_err",   64'(m_err_o),   64'h0);
      tick();
      s_ack_i   = 1'b0;
      m_write_i = '0;
      settle();
      chk("t1_gap_gnt", 64'(m_gnt_o),   64'h0);
      chk("t1_gap_swr", 64'(s_write_o), 64'h0);

      // 3. Read from master 2 with returned data
      m_read_i[2] = 1'b1;
      m_addr_i[2*AW +: AW] = 32'h0000_001D;
      tick();
      chk("t3_gnt",   64'(m_gnt_o),  64'h4);
      chk("t3_srd",   64'(s_read_o), 64'h1);
      chk("t3_saddr", 64'(s_addr_o), 64'h1D);
      s_rdata_i = 32'h0000_00A5;
      s_ack_i   = 1'b1;
      settle();
      chk("t3_ack",   64'(m_ack_o),   64'h4);
      chk("t3_rdata", 64'(m_rdata_o), 64'hA5);
      tick();
      s_ack_i   = 1'b0;
      s_rdata_i = '0;
      m_read_i  = '0;
      settle();
      chk("t3_idle", 64'(m_gnt_o), 64'h0);

      // 2. Fairness: all three read continuously, ack one cycle after strobe
      m_addr_i  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
      m_read_i  = 3'b111;
      for (int k = 0; k < 6; k++) begin
         exp_g = 3'b001 << (k % 3);
         tick();
         chk("t2_gnt",   64'(m_gnt_o),  64'(exp_g));
         chk("t2_saddr", 64'(s_addr_o), 64'((k % 3 + 1) * 256));
         chk("t2_wait",  64'(m_ack_o),  64'h0);
         tick();
         s_ack_i = 1'b1;
         settle();
         chk("t2_ack",   64'(m_ack_o),  64'(exp_g));
         tick();
         s_ack_i = 1'b0;
         if (k == 5) begin
            m_read_i = '0;
         end else begin
            m_read_i = m_read_i;
         end
         settle();
         chk("t2_gap", 64'(m_gnt_o), 64'h0);
      end

      // 4. Read+write together from master 0 while granted
      m_addr_i    = '0;
      m_read_i[0] = 1'b1;
      tick();
      chk("t4_gnt", 64'(m_gnt_o),  64'h1);
      chk("t4_srd", 64'(s_read_o), 64'h1);
      m_write_i[0] = 1'b1;
      settle();
      chk("t4_srd_sup", 64'(s_read_o),  64'h0);
      chk("t4_swr_sup", 64'(s_write_o), 64'h0);
      chk("t4_err",     64'(m_err_o),   64'h1);
      chk("t4_noack",   64'(m_ack_o),   64'h0);
      tick();
      m_read_i  = '0;
      m_write_i = '0;
      settle();
      chk("t4_idle",   64'(m_gnt_o), 64'h0);
      chk("t4_errclr", 64'(m_err_o), 64'h0);

      // Granted master withdraws before ack; stray slave ack in IDLE is ignored
      m_write_i[2] = 1'b1;
      tick();
      chk("drop_gnt", 64'(m_gnt_o), 64'h4);
      m_write_i = '0;
      settle();
      chk("drop_ack", 64'(m_ack_o),   64'h0);
      chk("drop_err", 64'(m_err_o),   64'h0);
      chk("drop_swr", 64'(s_write_o), 64'h0);
      tick();
      chk("drop_idle", 64'(m_gnt_o), 64'h0);
      s_ack_i = 1'b1;
      settle();
      chk("idle_ack_ign", 64'(m_ack_o), 64'h0);
      tick();
      s_ack_i = 1'b0;
      chk("idle_stay", 64'(m_gnt_o), 64'h0);

      // 5. Reset mid-BUSY
      m_read_i[1] = 1'b1;
      tick();
      chk("t5_gnt", 64'(m_gnt_o), 64'h2);
      m_read_i = 3'b011;
      rst      = 1'b1;
      settle();
      chk("t5_rst_gnt", 64'(m_gnt_o),  64'h0);
      chk("t5_rst_srd", 64'(s_read_o), 64'h0);
      chk("t5_rst_ack", 64'(m_ack_o),  64'h0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("t5_first", 64'(m_gnt_o), 64'h1);
      s_ack_i = 1'b1;
      settle();
      chk("t5_ack", 64'(m_ack_o), 64'h1);
      tick();
      s_ack_i  = 1'b0;
      m_read_i = '0;
      tick();

`ifdef BUS_ARB_TIMEOUT_EN
      // 6. Timeout after 8 BUSY cycles without ack, then the next requester wins
      m_read_i[2] = 1'b1;
      tick();
      chk("t6_gnt", 64'(m_gnt_o), 64'h4);
      m_read_i[0] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         settle();
         chk("t6_noerr", 64'(m_err_o), 64'h0);
         tick();
      end
      chk("t6_err",     64'(m_err_o),  64'h4);
      chk("t6_srd_sup", 64'(s_read_o), 64'h0);
      m_read_i[2] = 1'b0;
      tick();
      chk("t6_idle", 64'(m_gnt_o), 64'h0);
      tick();
      chk("t6_next", 64'(m_gnt_o), 64'h1);
      s_ack_i = 1'b1;
      settle();
      chk("t6_next_ack", 64'(m_ack_o), 64'h1);
      tick();
      s_ack_i  = 1'b0;
      m_read_i = '0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_bus_arbiter
